// File: rtl/img_pad_pkg.sv
// Shared geometry widths and FSM state encoding for the image border-padding stage.
package img_pad_pkg;

    localparam int unsigned GEOM_W = 12;
    localparam int unsigned OUTW_W = 13;
    localparam int unsigned PAD_W  = 8;

    typedef enum logic [2:0] {
        IDLE,
        TOP,
        LEFT,
        BODY,
        RIGHT,
        BOTTOM
    } state_t;

endpackage

// File: rtl/img_axis_oreg.sv
// Single-entry AXIS output register: loads a beat when empty or being drained.
module img_axis_oreg #(
    parameter int unsigned USER_W = 5,
    parameter int unsigned DEST_W = 2,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [USER_W-1:0] in_user,
    input  logic [DEST_W-1:0] in_dest,
    input  logic              in_last,
    input  logic [DATA_W-1:0] in_data,
    input  logic              ready,
    output logic              valid,
    output logic [USER_W-1:0] user,
    output logic [DEST_W-1:0] dest,
    output logic              last,
    output logic [DATA_W-1:0] data,
    output logic              can_load_c
);

    assign can_load_c = !valid || ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            user  <= '0;
            dest  <= '0;
            last  <= 1'b0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            user  <= in_user;
            dest  <= in_dest;
            last  <= in_last;
            data  <= in_data;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/img_pad.sv
// Surrounds each AXIS video frame with a constant-value border of configurable size.
module img_pad
    import img_pad_pkg::*;
#(
    parameter int unsigned TUSER_WIDTH = 5,
    parameter int unsigned TDEST_WIDTH = 2,
    parameter int unsigned TDATA_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [GEOM_W-1:0]      img_width,
    input  logic [GEOM_W-1:0]      img_height,
    input  logic [PAD_W-1:0]       pad_left,
    input  logic [PAD_W-1:0]       pad_right,
    input  logic [PAD_W-1:0]       pad_top,
    input  logic [PAD_W-1:0]       pad_bottom,
    input  logic [TDATA_WIDTH-1:0] pad_value,
    input  logic                   err_clr,
    input  logic [TUSER_WIDTH-1:0] s_axis_tuser,
    input  logic [TDEST_WIDTH-1:0] s_axis_tdest,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    input  logic                   s_axis_tlast,
    input  logic [TDATA_WIDTH-1:0] s_axis_tdata,
    output logic [TUSER_WIDTH-1:0] m_axis_tuser,
    output logic [TDEST_WIDTH-1:0] m_axis_tdest,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic                   m_axis_tlast,
    output logic [TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                   err_tlast,
    output logic                   frame_done
);

    state_t state, state_nxt;
    logic [GEOM_W-1:0] col, col_nxt, row, row_nxt;

    logic [GEOM_W-1:0]      w_q, h_q;
    logic [PAD_W-1:0]       pl_q, pr_q, pt_q, pb_q;
    logic [OUTW_W-1:0]      out_w_q;
    logic [TDATA_WIDTH-1:0] pv_q;
    logic [TUSER_WIDTH-1:0] user_q;
    logic [TDEST_WIDTH-1:0] dest_q;

    logic                   hold_valid, hold_last, first_q, run_q, fend_q;
    logic [TDATA_WIDTH-1:0] hold_data;

    logic                   can_load_c, gen_c, sof_c, err_set_c, row_end_c;
    logic                   beat_last_c, beat_fend_c;
    logic [TDATA_WIDTH-1:0] beat_data_c, src_data_c;
    logic [TUSER_WIDTH-1:0] beat_user_c;
    logic                   src_last_c, src_sof_c;

    // The SOF pixel captured in IDLE is replayed as the first body pixel.
    assign src_data_c = hold_valid ? hold_data : s_axis_tdata;
    assign src_last_c = hold_valid ? hold_last : s_axis_tlast;
    assign src_sof_c  = !hold_valid && s_axis_tuser[0];

    assign s_axis_tready = run_q && can_load_c &&
                           ((state == IDLE) || (state == BODY && !hold_valid));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            col   <= '0;
            row   <= '0;
        end else begin
            state <= state_nxt;
            col   <= col_nxt;
            row   <= row_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        col_nxt     = col;
        row_nxt     = row;
        gen_c       = 1'b0;
        sof_c       = 1'b0;
        err_set_c   = 1'b0;
        row_end_c   = 1'b0;
        beat_last_c = 1'b0;
        beat_fend_c = 1'b0;
        beat_data_c = pv_q;
        beat_user_c = user_q;
        beat_user_c[0] = first_q;
        case (state)
            IDLE: begin
                if (s_axis_tvalid && s_axis_tready && s_axis_tuser[0] &&
                    img_width != '0 && img_height != '0) begin
                    sof_c   = 1'b1;
                    col_nxt = '0;
                    row_nxt = '0;
                    if (pad_top != '0)       state_nxt = TOP;
                    else if (pad_left != '0) state_nxt = LEFT;
                    else                     state_nxt = BODY;
                end
            end
            TOP, BOTTOM: begin
                if (can_load_c) begin
                    gen_c = 1'b1;
                    if (OUTW_W'(col) + 13'd1 == out_w_q) begin
                        beat_last_c = 1'b1;
                        col_nxt     = '0;
                        if (row + 12'd1 == GEOM_W'((state == TOP) ? pt_q : pb_q)) begin
                            row_nxt = '0;
                            if (state == BOTTOM) begin
                                state_nxt   = IDLE;
                                beat_fend_c = 1'b1;
                            end else if (pl_q != '0) begin
                                state_nxt = LEFT;
                            end else begin
                                state_nxt = BODY;
                            end
                        end else begin
                            row_nxt = row + 12'd1;
                        end
                    end else begin
                        col_nxt = col + 12'd1;
                    end
                end
            end
            LEFT: begin
                if (can_load_c) begin
                    gen_c = 1'b1;
                    if (col + 12'd1 == GEOM_W'(pl_q)) begin
                        col_nxt   = '0;
                        state_nxt = BODY;
                    end else begin
                        col_nxt = col + 12'd1;
                    end
                end
            end
            BODY: begin
                if (can_load_c && (hold_valid || s_axis_tvalid)) begin
                    gen_c       = 1'b1;
                    beat_data_c = src_data_c;
                    err_set_c   = src_sof_c || (src_last_c != (col + 12'd1 == w_q));
                    if (col + 12'd1 == w_q) begin
                        col_nxt = '0;
                        if (pr_q != '0) begin
                            state_nxt = RIGHT;
                        end else begin
                            beat_last_c = 1'b1;
                            row_end_c   = 1'b1;
                        end
                    end else begin
                        col_nxt = col + 12'd1;
                    end
                end
            end
            RIGHT: begin
                if (can_load_c) begin
                    gen_c = 1'b1;
                    if (col + 12'd1 == GEOM_W'(pr_q)) begin
                        col_nxt     = '0;
                        beat_last_c = 1'b1;
                        row_end_c   = 1'b1;
                    end else begin
                        col_nxt = col + 12'd1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        // End of an image row: next body row, bottom border, or frame end.
        if (row_end_c) begin
            if (row + 12'd1 == h_q) begin
                row_nxt = '0;
                if (pb_q != '0) begin
                    state_nxt = BOTTOM;
                end else begin
                    state_nxt   = IDLE;
                    beat_fend_c = 1'b1;
                end
            end else begin
                row_nxt   = row + 12'd1;
                state_nxt = (pl_q != '0) ? LEFT : BODY;
            end
        end
    end

    // Frame geometry and sideband are frozen at SOF.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_q     <= '0;
            h_q     <= '0;
            pl_q    <= '0;
            pr_q    <= '0;
            pt_q    <= '0;
            pb_q    <= '0;
            out_w_q <= '0;
            pv_q    <= '0;
            user_q  <= '0;
            dest_q  <= '0;
        end else if (sof_c) begin
            w_q     <= img_width;
            h_q     <= img_height;
            pl_q    <= pad_left;
            pr_q    <= pad_right;
            pt_q    <= pad_top;
            pb_q    <= pad_bottom;
            out_w_q <= OUTW_W'(pad_left) + OUTW_W'(img_width) + OUTW_W'(pad_right);
            pv_q    <= pad_value;
            user_q  <= s_axis_tuser;
            dest_q  <= s_axis_tdest;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_q      <= 1'b0;
            hold_valid <= 1'b0;
            hold_last  <= 1'b0;
            hold_data  <= '0;
            first_q    <= 1'b0;
            fend_q     <= 1'b0;
            err_tlast  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            run_q <= 1'b1;
            if (sof_c) begin
                hold_valid <= 1'b1;
                hold_last  <= s_axis_tlast;
                hold_data  <= s_axis_tdata;
            end else if (state == BODY && gen_c) begin
                hold_valid <= 1'b0;
            end
            if (sof_c)      first_q <= 1'b1;
            else if (gen_c) first_q <= 1'b0;
            if (gen_c) fend_q <= beat_fend_c;
            if (err_set_c)    err_tlast <= 1'b1;
            else if (err_clr) err_tlast <= 1'b0;
            frame_done <= m_axis_tvalid && m_axis_tready && fend_q;
        end
    end

    img_axis_oreg #(
        .USER_W (TUSER_WIDTH),
        .DEST_W (TDEST_WIDTH),
        .DATA_W (TDATA_WIDTH)
    ) u_oreg (
        .clk        (clk),
        .rst        (rst),
        .load       (gen_c),
        .in_user    (beat_user_c),
        .in_dest    (dest_q),
        .in_last    (beat_last_c),
        .in_data    (beat_data_c),
        .ready      (m_axis_tready),
        .valid      (m_axis_tvalid),
        .user       (m_axis_tuser),
        .dest       (m_axis_tdest),
        .last       (m_axis_tlast),
        .data       (m_axis_tdata),
        .can_load_c (can_load_c)
    );

endmodule

// File: tb/tb_img_pad.sv
// Randomized self-checking bench for img_pad against a frame-level padding model.
module tb_img_pad;

    localparam int TU = 5;
    localparam int TD = 2;

    typedef struct packed {
        logic [TU-1:0] user;
        logic [TD-1:0] dest;
        logic          last;
        logic [7:0]    data;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [11:0]   img_width = 12'd4, img_height = 12'd2;
    logic [7:0]    pad_left = '0, pad_right = '0, pad_top = '0, pad_bottom = '0;
    logic [7:0]    pad_value = '0;
    logic          err_clr = 1'b0;
    logic [TU-1:0] s_axis_tuser = '0;
    logic [TD-1:0] s_axis_tdest = '0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tready;
    logic          s_axis_tlast = 1'b0;
    logic [7:0]    s_axis_tdata = '0;
    logic [TU-1:0] m_axis_tuser;
    logic [TD-1:0] m_axis_tdest;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b1;
    logic          m_axis_tlast;
    logic [7:0]    m_axis_tdata;
    logic          err_tlast;
    logic          frame_done;

    img_pad #(.TUSER_WIDTH(TU), .TDEST_WIDTH(TD), .TDATA_WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .img_width(img_width), .img_height(img_height),
        .pad_left(pad_left), .pad_right(pad_right), .pad_top(pad_top), .pad_bottom(pad_bottom),
        .pad_value(pad_value), .err_clr(err_clr),
        .s_axis_tuser(s_axis_tuser), .s_axis_tdest(s_axis_tdest), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast), .s_axis_tdata(s_axis_tdata),
        .m_axis_tuser(m_axis_tuser), .m_axis_tdest(m_axis_tdest), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast), .m_axis_tdata(m_axis_tdata),
        .err_tlast(err_tlast), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int    checks = 0;
    int    failures = 0;
    beat_t in_q[$];
    beat_t exp_q[$];
    beat_t obs_q[$];
    int    in_idx;
    int    fd_cnt;
    int    nframes;
    bit    rnd_rdy, rnd_vld, acc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Appends one frame of input beats and its padded reference output.
    task automatic add_frame(input int w, input int h, input int junk, input bit bad_tlast, input int sof_at);
        logic [7:0]    pix[$];
        beat_t         b;
        beat_t         e;
        logic [TU-1:0] u;
        logic [TD-1:0] d;
        int pl, pr, pt, pb, ow, oh;
        bit inb;
        u = TU'($urandom);
        u[0] = 1'b1;
        d = TD'($urandom);
        for (int j = 0; j < junk; j++) begin
            b.user = TU'($urandom);
            b.user[0] = 1'b0;
            b.dest = d;
            b.last = 1'($urandom);
            b.data = 8'($urandom);
            in_q.push_back(b);
        end
        for (int i = 0; i < w * h; i++) begin
            b.data = 8'($urandom);
            pix.push_back(b.data);
            b.user = (i == 0) ? u : '0;
            b.user[0] = (i == 0) || (i == sof_at);
            b.dest = d;
            b.last = (i % w) == w - 1;
            if (bad_tlast && i == 2) b.last = 1'b1;
            if (bad_tlast && i == 3) b.last = 1'b0;
            in_q.push_back(b);
        end
        pl = int'(pad_left);
        pr = int'(pad_right);
        pt = int'(pad_top);
        pb = int'(pad_bottom);
        ow = pl + w + pr;
        oh = pt + h + pb;
        for (int r = 0; r < oh; r++) begin
            for (int c = 0; c < ow; c++) begin
                inb = (r >= pt) && (r < pt + h) && (c >= pl) && (c < pl + w);
                e.data = inb ? pix[(r - pt) * w + (c - pl)] : pad_value;
                e.last = (c == ow - 1);
                e.user = u;
                e.user[0] = (r == 0) && (c == 0);
                e.dest = d;
                exp_q.push_back(e);
            end
        end
        nframes++;
    endtask

    task automatic clear_frames();
        in_q.delete();
        exp_q.delete();
        nframes = 0;
    endtask

    task automatic drive();
        m_axis_tready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        if (!(s_axis_tvalid && !acc))
            s_axis_tvalid = (in_idx < in_q.size()) && (rnd_vld ? 1'($urandom_range(0, 1)) : 1'b1);
        if (in_idx < in_q.size()) begin
            s_axis_tuser = in_q[in_idx].user;
            s_axis_tdest = in_q[in_idx].dest;
            s_axis_tlast = in_q[in_idx].last;
            s_axis_tdata = in_q[in_idx].data;
        end
    endtask

    // Streams in_q through the DUT while collecting every accepted output beat.
    task automatic run_frame(input int abort_at);
        int cyc;
        int tail;
        beat_t o;
        cyc = 0;
        tail = 0;
        obs_q.delete();
        in_idx = 0;
        fd_cnt = 0;
        acc = 1'b0;
        drive();
        while (cyc < 5000 && tail < 5) begin
            @(negedge clk);
            acc = s_axis_tvalid && s_axis_tready;
            if (m_axis_tvalid && m_axis_tready) begin
                o.user = m_axis_tuser;
                o.dest = m_axis_tdest;
                o.last = m_axis_tlast;
                o.data = m_axis_tdata;
                obs_q.push_back(o);
            end
            if (acc) in_idx++;
            if (frame_done) fd_cnt++;
            @(posedge clk);
            #1;
            cyc++;
            if (abort_at > 0 && obs_q.size() == abort_at) return;
            if (in_idx == in_q.size() && obs_q.size() >= exp_q.size()) tail++;
            drive();
        end
    endtask

    task automatic compare(input string tag);
        int n;
        chk({tag, "_beats"}, obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            chk($sformatf("%s_beat%0d", tag, i), 32'(obs_q[i]), 32'(exp_q[i]));
        chk({tag, "_consumed"}, in_idx, in_q.size());
        chk({tag, "_frame_done"}, fd_cnt, nframes);
    endtask

    task automatic set_pads(input int l, input int r, input int t, input int b);
        pad_left = 8'(l);
        pad_right = 8'(r);
        pad_top = 8'(t);
        pad_bottom = 8'(b);
    endtask

    initial begin
        rnd_rdy = 1'b0;
        rnd_vld = 1'b0;
        nframes = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_m_valid", m_axis_tvalid, 0);
        chk("rst_m_last", m_axis_tlast, 0);
        chk("rst_m_user", m_axis_tuser, 0);
        chk("rst_m_dest", m_axis_tdest, 0);
        chk("rst_m_data", m_axis_tdata, 0);
        chk("rst_s_ready", s_axis_tready, 0);
        chk("rst_err", err_tlast, 0);
        chk("rst_frame_done", frame_done, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("ready_before_edge", s_axis_tready, 0);
        @(negedge clk);
        chk("ready_after_edge", s_axis_tready, 1);
        @(posedge clk);
        #1;

        // 4x2 with a one-pixel black border
        clear_frames();
        img_width = 12'd4;
        img_height = 12'd2;
        set_pads(1, 1, 1, 1);
        pad_value = 8'h00;
        add_frame(4, 2, 0, 1'b0, -1);
        run_frame(0);
        compare("pad1");
        chk("pad1_err_clean", err_tlast, 0);

        // No padding: two frames pass through untouched
        clear_frames();
        img_width = 12'd5;
        img_height = 12'd3;
        set_pads(0, 0, 0, 0);
        add_frame(5, 3, 0, 1'b0, -1);
        add_frame(5, 3, 0, 1'b0, -1);
        run_frame(0);
        compare("nopad");

        // Same 6x4 frame under random backpressure and random source gaps
        clear_frames();
        rnd_rdy = 1'b1;
        rnd_vld = 1'b1;
        img_width = 12'd4;
        img_height = 12'd2;
        set_pads(1, 1, 1, 1);
        pad_value = 8'h5a;
        add_frame(4, 2, 0, 1'b0, -1);
        run_frame(0);
        compare("bp");

        // Early tlast in row 1: flagged, geometry unaffected
        clear_frames();
        rnd_rdy = 1'b0;
        rnd_vld = 1'b0;
        add_frame(4, 2, 0, 1'b1, -1);
        run_frame(0);
        compare("tlast_err");
        chk("err_set", err_tlast, 1);
        err_clr = 1'b1;
        @(posedge clk);
        #1 err_clr = 1'b0;
        @(negedge clk);
        chk("err_cleared", err_tlast, 0);
        @(posedge clk);
        #1;

        // SOF inside the body is a plain pixel and an error
        clear_frames();
        img_width = 12'd3;
        img_height = 12'd2;
        set_pads(2, 0, 0, 1);
        add_frame(3, 2, 0, 1'b0, 4);
        run_frame(0);
        compare("midsof");
        chk("midsof_err", err_tlast, 1);
        err_clr = 1'b1;
        @(posedge clk);
        #1 err_clr = 1'b0;

        // Zero width: SOF dropped, nothing emitted
        clear_frames();
        img_width = 12'd0;
        img_height = 12'd2;
        begin
            beat_t z;
            z.user = 5'b00001;
            z.dest = '0;
            z.last = 1'b0;
            z.data = 8'h77;
            in_q.push_back(z);
        end
        run_frame(0);
        compare("zero_w");

        // Random geometries with random handshakes
        rnd_rdy = 1'b1;
        rnd_vld = 1'b1;
        for (int k = 0; k < 6; k++) begin
            int w, h;
            clear_frames();
            w = $urandom_range(1, 6);
            h = $urandom_range(1, 4);
            img_width = 12'(w);
            img_height = 12'(h);
            set_pads($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
            pad_value = 8'($urandom);
            add_frame(w, h, $urandom_range(0, 2), 1'b0, -1);
            run_frame(0);
            compare($sformatf("rnd%0d", k));
        end
        chk("rnd_err_clean", err_tlast, 0);

        // Junk before SOF, then reset after the 10th output beat
        rnd_rdy = 1'b0;
        rnd_vld = 1'b0;
        clear_frames();
        img_width = 12'd4;
        img_height = 12'd2;
        set_pads(1, 1, 1, 1);
        pad_value = 8'h00;
        add_frame(4, 2, 3, 1'b0, -1);
        run_frame(10);
        chk("abort_beats", obs_q.size(), 10);
        rst = 1'b1;
        s_axis_tvalid = 1'b0;
        @(negedge clk);
        chk("abort_valid", m_axis_tvalid, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("abort_valid_hold", m_axis_tvalid, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        clear_frames();
        add_frame(4, 2, 3, 1'b0, -1);
        run_frame(0);
        compare("after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/img_pad.md
IMG_PAD -- requirements
Module: img_pad

Interface
REQ-001 Parameters SHALL be: TUSER_WIDTH, default 5, AXIS tuser width; TDEST_WIDTH, default 2, AXIS tdest width; TDATA_WIDTH, default 8, one pixel per beat.
REQ-002 Ports SHALL be, clock and reset first:
- clk  in  1  single clock
- rst  in  1  reset, asynchronous, active-high
- img_width  in  12  input row length, pixels
- img_height  in  12  input row count
- pad_left, pad_right, pad_top, pad_bottom  in  8 each  border sizes
- pad_value  in  TDATA_WIDTH  border pixel value
- err_clr  in  1  clears err_tlast
- s_axis_tuser/tdest/tvalid/tready/tlast/tdata  AXIS slave; tuser[0] marks SOF, tlast marks EOL
- m_axis_tuser/tdest/tvalid/tready/tlast/tdata  AXIS master, same meaning
- err_tlast  out  1  sticky input-row-length mismatch
- frame_done  out  1  one-cycle pulse after last output beat of a frame

Function
REQ-003 The block SHALL sit downstream of img_crop and emit each frame surrounded by a constant border: out_w = pad_left+img_width+pad_right, out_h = pad_top+img_height+pad_bottom.
REQ-004 The FSM SHALL have states IDLE, TOP, LEFT, BODY, RIGHT, BOTTOM.
REQ-005 IDLE: s_axis_tready=1; non-SOF beats SHALL be accepted and dropped; an accepted SOF beat SHALL latch all config, tuser and tdest, and SHALL be held as the first BODY pixel.
REQ-006 Transitions from IDLE: to TOP if pad_top>0, else LEFT if pad_left>0, else BODY.
REQ-007 TOP/BOTTOM SHALL emit pad rows of out_w beats; LEFT and RIGHT SHALL emit pad_left and pad_right beats; BODY SHALL pass exactly img_width input beats; states with zero count SHALL be skipped.
REQ-008 Row order: pad_top rows, then img_height rows of LEFT,BODY,RIGHT, then pad_bottom rows, then IDLE.
REQ-009 Pad beats SHALL carry tdata=pad_value; body beats SHALL carry the input tdata unchanged.
REQ-010 m_axis_tuser[0] SHALL be 1 only on the first output beat of a frame; tuser[TUSER_WIDTH-1:1] and tdest SHALL be the values latched at SOF.
REQ-011 m_axis_tlast SHALL be 1 on the final beat of every output row, independent of input tlast.
REQ-012 Output SHALL be one registered stage: data presented the cycle after acceptance/generation; a beat SHALL be produced only when the output register is empty or m_axis_tready=1.
REQ-013 s_axis_tready SHALL be 1 only in IDLE or BODY, and only when the output register can accept a beat; it SHALL be 0 in all pad states.
REQ-014 Output SHALL stay stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-015 Input tlast on a BODY beat other than the img_width-th, or absence of tlast on the img_width-th, SHALL set err_tlast; the FSM SHALL still consume exactly img_width beats per row.
REQ-016 An input SOF outside IDLE SHALL be treated as an ordinary pixel and SHALL set err_tlast; resync occurs at the next SOF seen in IDLE.
REQ-017 err_tlast SHALL clear on err_clr; if set and clear coincide, set wins.
REQ-018 Config changes mid-frame SHALL have no effect until the next SOF.
REQ-019 img_width=0 or img_height=0 SHALL make the SOF beat be dropped and the FSM stay in IDLE.
REQ-020 out_w and out_h SHALL be computed in 13 bits; values above 4095 are unsupported.
REQ-021 Column and row counters SHALL be 12 bits and reset at each state/row boundary.
REQ-022 frame_done SHALL pulse for one cycle on the cycle after the last beat of a frame is accepted by the downstream stage.

Reset
REQ-023 On rst: state=IDLE, counters=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tuser=0, m_axis_tdest=0, m_axis_tdata=0, s_axis_tready=0, err_tlast=0, frame_done=0.
REQ-024 s_axis_tready SHALL rise on the first clock edge after rst deasserts.
REQ-025 Reset mid-frame SHALL discard the partial frame, with no output beats after rst asserts.

Structure
REQ-026 Package img_pad_pkg SHALL hold the FSM state enum and the 12/13-bit geometry width constants.
REQ-027 The output register SHALL be one sub-module, img_axis_oreg, shared with other lab stages.

Verification
REQ-028 4x2 input, all pads=1, pad_value=0x00 -> 6x4 output, 24 beats, tlast on beats 6/12/18/24, tuser[0] only on beat 1, body at rows 2-3, columns 2-5.
REQ-029 All pads=0 -> output beat-identical to input; frame_done once per frame.
REQ-030 Same as REQ-028 with random m_axis_tready (50%) and random s_axis_tvalid -> identical 24-beat sequence, no beat lost or duplicated.
REQ-031 img_width=4 with tlast on the 3rd beat of row 1 -> err_tlast=1, output still 6x4; err_clr -> err_tlast=0.
REQ-032 Three non-SOF beats before SOF -> dropped, no output; rst asserted at output beat 10 -> m_axis_tvalid=0 next edge; the next full frame is correct.
